// File: rtl/seg_scan_reader.sv
// seg_scan_reader: recovers BCD digits from a multiplexed 7-segment bus once each pattern is stable.
module seg_scan_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     dig_valid,
  output logic                  upd,
  output logic [2:0]            upd_idx,
  output logic                  code_err
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  state_t state, state_nx;
  logic [DIGITS+6:0] smp, smp_in;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DIGITS-1:0] sel;
  logic [6:0] seg;
  logic [3:0] dec;
  logic [2:0] idx;
  logic chg, cap, multi, wr;
  assign sel = smp[DIGITS+6:7];
  assign seg = smp[6:0];
  always_comb begin
    smp_in   = {dig_sel, seg_in};
    chg      = smp_in != smp;
    cap      = state == SETTLE && cnt == CW'(STABLE_CYC);
    cnt_nx   = chg ? CW'(1) : (cnt == CW'(STABLE_CYC) ? cnt : cnt + 1'b1);
    state_nx = chg ? (dig_sel == '0 ? IDLE : SETTLE) : (cap ? HELD : state);
  end
  always_comb begin
    idx   = '0;
    multi = $countones(sel) > 1;
    wr    = cap && !multi;
    for (int k = 0; k < DIGITS; k++)
      if (sel[k]) idx = 3'(k);
  end
  always_comb begin
    case (seg)
      7'b1111110: dec = 4'd0;
      7'b0110000: dec = 4'd1;
      7'b1101101: dec = 4'd2;
      7'b1111001: dec = 4'd3;
      7'b0110011: dec = 4'd4;
      7'b1011011: dec = 4'd5;
      7'b1011111: dec = 4'd6;
      7'b1110000: dec = 4'd7;
      7'b1111111: dec = 4'd8;
      7'b1111011: dec = 4'd9;
      7'b0000000: dec = 4'hF;
      default:    dec = 4'hE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp       <= '0;
      cnt       <= '0;
      state     <= IDLE;
      bcd_out   <= '1;
      dig_valid <= '0;
      upd       <= 1'b0;
      upd_idx   <= '0;
      code_err  <= 1'b0;
    end else begin
      smp      <= smp_in;
      cnt      <= cnt_nx;
      state    <= state_nx;
      upd      <= wr;
      code_err <= cap && (multi || dec == 4'hE);
      if (wr) upd_idx <= idx;
      for (int k = 0; k < DIGITS; k++)
        if (wr && sel[k]) begin
          bcd_out[4*k +: 4] <= dec;
          dig_valid[k]      <= dec < 4'd10;
        end
    end
  end
endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: directed and random checks of seg_scan_reader against a run-length reference model.
module tb_seg_scan_reader;
  logic clk = 1'b0, rst_n = 1'b0, upd, code_err;
  logic [6:0] seg_in = '0;
  logic [3:0] dig_sel = '0, dig_valid;
  logic [15:0] bcd_out;
  logic [2:0] upd_idx;
  int tests = 0, fails = 0, upd_cnt = 0, run = 0;
  logic [15:0] exp_bcd = 16'hFFFF;
  logic [3:0] exp_val = '0;
  logic e_upd = 1'b0, e_err = 1'b0;
  logic [2:0] e_idx = '0;
  logic [10:0] last = '0;
  logic [6:0] pats [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  seg_scan_reader #(.DIGITS(4), .STABLE_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel), .bcd_out(bcd_out),
    .dig_valid(dig_valid), .upd(upd), .upd_idx(upd_idx), .code_err(code_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: a digit is captured on the edge after the 4th identical sample of a window.
  task automatic step(input logic r, input logic [3:0] sel, input logic [6:0] seg);
    int d;
    logic [3:0] s;
    logic [6:0] g;
    rst_n = r; dig_sel = sel; seg_in = seg;
    @(posedge clk);
    e_upd = 1'b0; e_err = 1'b0;
    if (!r) begin
      exp_bcd = 16'hFFFF; exp_val = '0; e_idx = '0; run = 0;
    end else begin
      if (run == 4 && last[10:7] != 0) begin
        s = last[10:7]; g = last[6:0];
        if ($countones(s) > 1) e_err = 1'b1;
        else begin
          d = -1;
          for (int v = 0; v < 10; v++) if (pats[v] == g) d = v;
          for (int k = 0; k < 4; k++) if (s[k]) e_idx = 3'(k);
          e_upd = 1'b1;
          exp_bcd[4*e_idx +: 4] = d >= 0 ? 4'(d) : (g == 0 ? 4'hF : 4'hE);
          exp_val[e_idx] = d >= 0;
          e_err = d < 0 && g != 0;
        end
      end
      if (run == 0 || {sel, seg} != last) begin
        last = {sel, seg}; run = 1;
      end else run++;
    end
    #1;
    if (upd === 1'b1) upd_cnt++;
    chk("upd", 16'(upd), 16'(e_upd));
    chk("code_err", 16'(code_err), 16'(e_err));
    chk("bcd_out", bcd_out, exp_bcd);
    chk("dig_valid", 16'(dig_valid), 16'(exp_val));
    if (e_upd) chk("upd_idx", 16'(upd_idx), 16'(e_idx));
  endtask

  task automatic hold(input int n, input logic [3:0] sel, input logic [6:0] seg);
    for (int i = 0; i < n; i++) step(1'b1, sel, seg);
  endtask

  initial begin
    logic [3:0] rs;
    logic [6:0] rg;
    int hl;
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0, 7'b0);
    chk("rst_bcd", bcd_out, 16'hFFFF);
    chk("rst_valid", 16'(dig_valid), 16'h0);
    upd_cnt = 0;
    hold(4, 4'b0001, 7'b1111110);
    chk("zero_latency_none", 16'(upd_cnt), 16'd0);
    hold(6, 4'b0001, 7'b1111110);
    chk("zero_once", 16'(upd_cnt), 16'd1);
    chk("zero_bcd", 16'(bcd_out[3:0]), 16'h0);
    chk("zero_valid", 16'(dig_valid), 16'h1);
    upd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      hold(3, 4'b0010, 7'b1111001);
      hold(3, 4'b0010, 7'b0110000);
    end
    chk("toggle_no_upd", 16'(upd_cnt), 16'd0);
    upd_cnt = 0;
    hold(8, 4'b0001, pats[1]);
    hold(8, 4'b0010, pats[2]);
    hold(8, 4'b0100, pats[3]);
    hold(8, 4'b1000, pats[9]);
    step(1'b1, 4'b0000, 7'b0);
    chk("scan_bcd", bcd_out, 16'h9321);
    chk("scan_valid", 16'(dig_valid), 16'hF);
    chk("scan_upd4", 16'(upd_cnt), 16'd4);
    hold(6, 4'b0100, 7'b1000000);
    chk("illegal_bcd", bcd_out, 16'h9E21);
    chk("illegal_valid", 16'(dig_valid), 16'hB);
    upd_cnt = 0;
    hold(6, 4'b0011, 7'b1111110);
    chk("multi_no_upd", 16'(upd_cnt), 16'd0);
    chk("multi_bcd", bcd_out, 16'h9E21);
    hold(2, 4'b0100, pats[5]);
    step(1'b0, 4'b0100, pats[5]);
    upd_cnt = 0;
    hold(4, 4'b0100, pats[5]);
    chk("rst_mid_none", 16'(upd_cnt), 16'd0);
    hold(2, 4'b0100, pats[5]);
    chk("rst_mid_cap", 16'(upd_cnt), 16'd1);
    for (int n = 0; n < 300; n++) begin
      hl = $urandom_range(0, 9);
      rs = hl < 6 ? 4'(1 << $urandom_range(0, 3)) : (hl == 6 ? 4'b0 : 4'($urandom));
      hl = $urandom_range(0, 9);
      rg = hl < 6 ? pats[$urandom_range(0, 9)] : (hl == 6 ? 7'b0 : 7'($urandom));
      if ($urandom_range(0, 39) == 0) step(1'b0, rs, rg);
      hold($urandom_range(1, 7), rs, rg);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
